// File: rtl/upg_pkg.sv
// rtl/upg_pkg.sv - shared types and constants for the UART programming loader
package upg_pkg;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_WORD,
    S_ACK,
    S_DONE,
    S_ERR
  } upg_state_t;

  localparam logic       SEC_IMEM    = 1'b0;
  localparam logic       SEC_DMEM    = 1'b1;
  localparam logic [7:0] ACK_OK_DEF  = 8'h4F;
  localparam logic [7:0] ACK_ERR_DEF = 8'h45;
  localparam int         ADDR_W      = 14;

endpackage

// File: rtl/upg_word_asm.sv
// rtl/upg_word_asm.sv - little-endian byte-to-word assembler with byte index
module upg_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;
  logic [1:0]  bidx;

  // Bytes enter at the top and drift down, so byte 0 ends up in bits 7:0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bidx  <= '0;
    end else if (clr) begin
      bidx  <= '0;
    end else if (byte_valid) begin
      shreg <= {byte_data, shreg[23:8]};
      bidx  <= bidx + 2'd1;
    end
  end

  assign word_valid = byte_valid && (bidx == 2'd3);
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/upg_loader.sv
// rtl/upg_loader.sv - parses a two-section UART image into imem/dmem word writes
module upg_loader
  import upg_pkg::*;
#(
  parameter int         IMEM_WORDS = 16384,
  parameter int         DMEM_WORDS = 16384,
  parameter logic [7:0] ACK_OK     = ACK_OK_DEF,
  parameter logic [7:0] ACK_ERR    = ACK_ERR_DEF
) (
  input  logic        upg_clk_i,
  input  logic        upg_rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o
);

  upg_state_t        state;
  logic              sec;
  logic              err_sent;
  logic [15:0]       cnt;
  logic [15:0]       cnt_new;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       limit;
  logic              last_word;
  logic              asm_clr;
  logic              asm_byte;
  logic              word_valid;
  logic [31:0]       word;

  assign cnt_new   = {rx_data_i, cnt[7:0]};
  assign limit     = (sec == SEC_DMEM) ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);
  assign last_word = ({{(16-ADDR_W){1'b0}}, widx} == (cnt - 16'd1));
  assign asm_clr   = (state == S_CNT_HI) && rx_valid_i;
  assign asm_byte  = (state == S_WORD) && rx_valid_i;

  upg_word_asm u_word_asm (
    .clk        (upg_clk_i),
    .rst_n      (upg_rstn_i),
    .clr        (asm_clr),
    .byte_valid (asm_byte),
    .byte_data  (rx_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      state      <= S_CNT_LO;
      sec        <= SEC_IMEM;
      err_sent   <= 1'b0;
      cnt        <= '0;
      widx       <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      case (state)
        S_CNT_LO: begin
          if (rx_valid_i) begin
            cnt[7:0] <= rx_data_i;
            state    <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (rx_valid_i) begin
            cnt[15:8] <= rx_data_i;
            if ({16'd0, cnt_new} > limit) begin
              state <= S_ERR;
            end else if (cnt_new == 16'd0) begin
              if (sec == SEC_IMEM) begin
                sec   <= SEC_DMEM;
                state <= S_CNT_LO;
              end else begin
                state <= S_ACK;
              end
            end else begin
              widx  <= '0;
              state <= S_WORD;
            end
          end
        end
        S_WORD: begin
          if (word_valid) begin
            upg_wen_o <= 1'b1;
            upg_adr_o <= {sec, widx};
            upg_dat_o <= word;
            widx      <= widx + 1'b1;
            if (last_word) begin
              if (sec == SEC_IMEM) begin
                sec   <= SEC_DMEM;
                state <= S_CNT_LO;
              end else begin
                state <= S_ACK;
              end
            end
          end
        end
        S_ACK: begin
          if (tx_valid_o && tx_ready_i) begin
            tx_valid_o <= 1'b0;
            upg_done_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= ACK_OK;
          end
        end
        S_DONE: begin
          upg_done_o <= 1'b1;
        end
        S_ERR: begin
          // The error byte goes out exactly once; afterwards the block is inert.
          if (tx_valid_o && tx_ready_i) begin
            tx_valid_o <= 1'b0;
            err_sent   <= 1'b1;
          end else if (!err_sent) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= ACK_ERR;
          end
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_upg_loader.sv
// tb/tb_upg_loader.sv - self-checking bench for upg_loader
module tb_upg_loader;

  logic        upg_clk_i;
  logic        upg_rstn_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;

  upg_loader dut (
    .upg_clk_i  (upg_clk_i),
    .upg_rstn_i (upg_rstn_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o)
  );

  initial upg_clk_i = 1'b0;
  always #50 upg_clk_i = ~upg_clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [14:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic        exp_ok     = 1'b1;
  logic [7:0]  exp_tx     = 8'h4F;
  logic        model_done = 1'b0;
  int          wr_count   = 0;
  int          hs_count   = 0;
  logic [14:0] last_adr   = '0;
  logic [31:0] last_dat   = '0;
  logic        prev_txv   = 1'b0;
  logic        prev_rdy   = 1'b0;
  logic        prev_wen   = 1'b0;
  logic [7:0]  prev_data  = '0;
  int          wr0, hs0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Per-cycle comparison against the image-level model.
  always @(negedge upg_clk_i) begin
    if (!upg_rstn_i) begin
      check("reset_outs", {upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, tx_valid_o, tx_data_o}, 64'd0);
      model_done = 1'b0;
      prev_txv   = 1'b0;
      prev_rdy   = 1'b0;
      prev_wen   = 1'b0;
    end else begin
      if (upg_wen_o) begin
        if (exp_adr.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          check("wr_adr", upg_adr_o, exp_adr.pop_front());
          check("wr_dat", upg_dat_o, exp_dat.pop_front());
        end
        wr_count++;
        last_adr = upg_adr_o;
        last_dat = upg_dat_o;
      end
      if (prev_wen) check("wen_pulse", upg_wen_o, 0);
      check("done", upg_done_o, model_done);
      if (prev_txv && !prev_rdy) check("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_data});
      if (prev_txv && prev_rdy) check("tx_drop", tx_valid_o, 0);
      if (tx_valid_o) check("tx_data", tx_data_o, exp_tx);
      if (tx_valid_o && tx_ready_i) begin
        hs_count++;
        if (exp_ok) model_done = 1'b1;
      end
      prev_txv  = tx_valid_o;
      prev_rdy  = tx_ready_i;
      prev_wen  = upg_wen_o;
      prev_data = tx_data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge upg_clk_i); #1;
  endtask

  task automatic idle(input int n);
    rx_valid_i = 1'b0;
    repeat (n) begin @(posedge upg_clk_i); #1; end
  endtask

  task automatic send_cnt(input logic [15:0] c);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
  endtask

  // Model: word idx of a section lands at section*0x4000 + idx.
  task automatic load_word(input logic sec, input int idx, input logic [31:0] w);
    exp_adr.push_back({sec, 14'(idx)});
    exp_dat.push_back(w);
    send_word(w);
  endtask

  task automatic do_reset();
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    upg_rstn_i = 1'b0;
    exp_adr.delete();
    exp_dat.delete();
    repeat (2) begin @(posedge upg_clk_i); #1; end
    upg_rstn_i = 1'b1;
    @(posedge upg_clk_i); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !upg_done_o; i++) begin @(posedge upg_clk_i); #1; end
    check("done_timeout", upg_done_o, 1);
  endtask

  task automatic mark();
    wr0 = wr_count;
    hs0 = hs_count;
  endtask

  initial begin
    rx_data_i  = '0;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    upg_rstn_i = 1'b0;
    #1;
    check("async_reset", {upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, tx_valid_o, tx_data_o}, 64'd0);

    // Two-section image, back-to-back bytes.
    do_reset();
    mark();
    exp_ok = 1'b1; exp_tx = 8'h4F;
    send_cnt(16'd2);
    load_word(1'b0, 0, 32'h11223344);
    load_word(1'b0, 1, 32'hAABBCCDD);
    send_cnt(16'd1);
    load_word(1'b1, 0, 32'hDEADBEEF);
    idle(1);
    wait_done();
    check("t1_wr_count", wr_count - wr0, 3);
    check("t1_last_adr", last_adr, 15'h4000);
    check("t1_last_dat", last_dat, 32'hDEADBEEF);
    check("t1_hs", hs_count - hs0, 1);
    check("t1_pending", exp_adr.size(), 0);

    // Both sections empty.
    do_reset();
    mark();
    send_cnt(16'd0);
    send_cnt(16'd0);
    idle(1);
    wait_done();
    check("t2_wr_count", wr_count - wr0, 0);
    check("t2_hs", hs_count - hs0, 1);

    // Oversized instruction section.
    do_reset();
    mark();
    exp_ok = 1'b0; exp_tx = 8'h45;
    send_cnt(16'h4001);
    send_word(32'h01020304);
    send_word(32'h05060708);
    idle(30);
    check("t3_hs", hs_count - hs0, 1);
    check("t3_wr_count", wr_count - wr0, 0);
    check("t3_done", upg_done_o, 0);
    check("t3_txv", tx_valid_o, 0);

    // Transmitter stalled after the last word.
    do_reset();
    mark();
    exp_ok = 1'b1; exp_tx = 8'h4F;
    tx_ready_i = 1'b0;
    send_cnt(16'd0);
    send_cnt(16'd1);
    load_word(1'b1, 0, 32'h55AA55AA);
    idle(20);
    check("t4_txv", tx_valid_o, 1);
    check("t4_txd", tx_data_o, 8'h4F);
    check("t4_done_early", upg_done_o, 0);
    tx_ready_i = 1'b1;
    wait_done();
    check("t4_hs", hs_count - hs0, 1);
    check("t4_last_adr", last_adr, 15'h4000);

    // Reset two bytes into a word, then a fresh image.
    do_reset();
    mark();
    send_cnt(16'd2);
    load_word(1'b0, 0, 32'h12345678);
    send_byte(8'h9A);
    send_byte(8'hBC);
    rx_valid_i = 1'b0;
    upg_rstn_i = 1'b0;
    #1;
    check("t5_abort", {upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, tx_valid_o, tx_data_o}, 64'd0);
    check("t5_wr_count", wr_count - wr0, 1);
    do_reset();
    mark();
    send_cnt(16'd1);
    load_word(1'b0, 0, 32'hCAFEF00D);
    send_cnt(16'd0);
    idle(1);
    wait_done();
    check("t5_wr_count2", wr_count - wr0, 1);
    check("t5_last_adr", last_adr, 15'h0000);
    check("t5_last_dat", last_dat, 32'hCAFEF00D);

    // Instruction section at the full limit.
    do_reset();
    mark();
    send_cnt(16'd16384);
    for (int i = 0; i < 16384; i++) load_word(1'b0, i, 32'hA5000000 ^ i);
    idle(2);
    check("t6_wr_count", wr_count - wr0, 16384);
    check("t6_last_adr", last_adr, 15'h3FFF);
    check("t6_last_dat", last_dat, 32'hA5003FFF);
    check("t6_done_early", upg_done_o, 0);
    send_cnt(16'd1);
    load_word(1'b1, 0, 32'h0BADF00D);
    idle(1);
    wait_done();
    check("t6_dmem_adr", last_adr, 15'h4000);
    check("t6_pending", exp_adr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
